// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter: round-robin arbiter sharing one i2c_com write engine
// between NUM_REQ camera register-configuration sequencers. It owns the
// start/i2c_data/tr_end handshake and returns per-requester done/err pulses.
module i2c_cfg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4095
) (
    input  logic                         clock_i2c,
    input  logic                         camera_rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   cur_id,
    output logic [DATA_W-1:0]            i2c_data,
    output logic                         start,
    input  logic                         tr_end,
    input  logic                         ack
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_END,
        S_RELEASE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_done, w_done_nxt;
    logic [NUM_REQ-1:0]  r_err, w_err_nxt;
    logic                r_busy, w_busy_nxt;
    logic [ID_W-1:0]     r_cur_id, w_cur_id_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_start, w_start_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    // Scan start position: requester after the last winner (0 after reset).
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;

    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_win_inc;

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign err      = r_err;
    assign busy     = r_busy;
    assign cur_id   = r_cur_id;
    assign i2c_data = r_data;
    assign start    = r_start;

    // Round-robin pick: first set req bit scanning upward from r_ptr with wrap.
    always_comb begin
        int unsigned k;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = int'(r_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_win   = ID_W'(k);
            end
        end
        w_win_inc = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_err_nxt    = '0;
        w_cur_id_nxt = r_cur_id;
        w_data_nxt   = r_data;
        w_start_nxt  = r_start;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_cur_id_nxt     = w_win;
                    w_data_nxt       = req_data[w_win*DATA_W +: DATA_W];
                    w_start_nxt      = 1'b1;
                    w_cnt_nxt        = '0;
                    w_ptr_nxt        = w_win_inc;
                    w_state_nxt      = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                // tr_end is checked first so it wins over a simultaneous timeout.
                if (tr_end) begin
                    w_start_nxt          = 1'b0;
                    w_gnt_nxt            = '0;
                    w_done_nxt[r_cur_id] = 1'b1;
                    w_err_nxt[r_cur_id]  = ~ack;
                    w_state_nxt          = S_RELEASE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_start_nxt          = 1'b0;
                    w_gnt_nxt            = '0;
                    w_done_nxt[r_cur_id] = 1'b1;
                    w_err_nxt[r_cur_id]  = 1'b1;
                    w_state_nxt          = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                // Hold off until the engine drops tr_end so it cannot end the next transfer.
                if (!tr_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clock_i2c) begin
        if (camera_rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_cur_id <= '0;
            r_data   <= '0;
            r_start  <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_cur_id <= w_cur_id_nxt;
            r_data   <= w_data_nxt;
            r_start  <= w_start_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed testbench for i2c_cfg_arbiter: one instance with default timeout
// for arbitration/handshake scenarios, one with TIMEOUT=16 for abort cases.
module tb_i2c_cfg_arbiter;

    logic         clk = 1'b0;
    logic         camera_rst;
    logic [3:0]   req, req2;
    logic [127:0] req_data;
    logic [3:0]   gnt, done, err, gnt2, done2, err2;
    logic         busy, busy2, start, start2;
    logic [1:0]   cur_id, cur_id2;
    logic [31:0]  i2c_data, i2c_data2;
    logic         tr_end, ack, tr_end2, ack2;

    logic [31:0]  words [4];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    i2c_cfg_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(4095)) dut (
        .clock_i2c(clk), .camera_rst(camera_rst), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .cur_id(cur_id),
        .i2c_data(i2c_data), .start(start), .tr_end(tr_end), .ack(ack)
    );

    i2c_cfg_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(16)) dut_to (
        .clock_i2c(clk), .camera_rst(camera_rst), .req(req2), .req_data(req_data),
        .gnt(gnt2), .done(done2), .err(err2), .busy(busy2), .cur_id(cur_id2),
        .i2c_data(i2c_data2), .start(start2), .tr_end(tr_end2), .ack(ack2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        camera_rst = 1'b1;
        req = '0; req2 = '0;
        tr_end = 1'b0; tr_end2 = 1'b0;
        ack = 1'b1; ack2 = 1'b1;
        tick; tick;
        camera_rst = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_id", cur_id, 0);
        check("rst_data", i2c_data, 0);
        check("rst_done", done, 0);
    endtask

    task automatic t_grant(input int id);
        tick;
        check("gnt", gnt, 64'(1) << id);
        check("start", start, 1);
        check("cur_id", cur_id, id);
        check("i2c_data", i2c_data, words[id]);
        check("busy", busy, 1);
        check("done_early", done, 0);
    endtask

    task automatic t_end(input int id, input logic ackv, input int n);
        repeat (n) tick;
        check("start_hold", start, 1);
        tr_end = 1'b1; ack = ackv;
        tick;
        check("done", done, 64'(1) << id);
        check("err", err, ackv ? 64'd0 : (64'(1) << id));
        check("start_drop", start, 0);
        check("gnt_drop", gnt, 0);
        check("busy_release", busy, 1);
        tr_end = 1'b0; ack = 1'b1;
        tick;
        check("done_pulse", done, 0);
        check("err_pulse", err, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        words[0] = 32'hA0123456;
        words[1] = 32'h78310311;
        words[2] = 32'hC2ABCDEF;
        words[3] = 32'hD3F00D55;
        req_data = {words[3], words[2], words[1], words[0]};
        do_reset;

        // Single request; req dropped mid-transfer must not disturb completion
        req = 4'b0010;
        t_grant(1);
        req = 4'b0000;
        t_end(1, 1'b1, 39);

        // All requesters pending: strict rotation 0,1,2,3,0
        do_reset;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            t_grant(k % 4);
            if (k == 4) req = 4'b0000;
            t_end(k % 4, 1'b1, 2 + k);
        end

        // Fairness: held req[0] yields to req[2] raised during 0's transfer
        do_reset;
        req = 4'b0001;
        t_grant(0);
        req = 4'b0101;
        t_end(0, 1'b1, 5);
        t_grant(2);
        t_end(2, 1'b1, 3);
        t_grant(0);
        req = 4'b0000;
        t_end(0, 1'b1, 1);

        // NACK: done and err together, then normal rotation
        do_reset;
        req = 4'b0010;
        t_grant(1);
        t_end(1, 1'b0, 3);
        req = 4'b0110;
        t_grant(2);
        req = 4'b0000;
        t_end(2, 1'b1, 2);

        // Reset during WAIT_END
        do_reset;
        req = 4'b0100;
        t_grant(2);
        repeat (5) tick;
        camera_rst = 1'b1;
        tick;
        check("mid_rst_start", start, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", i2c_data, 0);
        camera_rst = 1'b0;
        req = 4'b1000;
        t_grant(3);
        req = 4'b0000;
        t_end(3, 1'b1, 2);
        do_reset;
        req = 4'b1001;
        t_grant(0);
        req = 4'b0000;
        t_end(0, 1'b1, 1);

        // Timeout (TIMEOUT=16): abort on the 16th cycle after start
        do_reset;
        req2 = 4'b0001;
        tick;
        check("to_gnt", gnt2, 4'b0001);
        check("to_start", start2, 1);
        req2 = 4'b0000;
        repeat (15) tick;
        check("to_start_15", start2, 1);
        check("to_done_15", done2, 0);
        tick;
        check("to_start_16", start2, 0);
        check("to_done_16", done2, 4'b0001);
        check("to_err_16", err2, 4'b0001);
        check("to_gnt_16", gnt2, 0);
        tr_end2 = 1'b1;
        tick;
        check("to_done_pulse", done2, 0);
        check("to_err_pulse", err2, 0);
        check("to_busy_rel", busy2, 1);
        repeat (3) tick;
        check("to_busy_hold", busy2, 1);
        tr_end2 = 1'b0;
        tick;
        check("to_busy_idle", busy2, 0);

        // tr_end on the timeout cycle: tr_end wins, err follows ack
        req2 = 4'b0100;
        tick;
        check("tie_gnt", gnt2, 4'b0100);
        req2 = 4'b0000;
        repeat (15) tick;
        tr_end2 = 1'b1; ack2 = 1'b1;
        tick;
        check("tie_done", done2, 4'b0100);
        check("tie_err", err2, 0);
        tr_end2 = 1'b0;
        tick;
        check("tie_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_arbiter.md
Name: i2c_cfg_arbiter

Overview:
- Shares the single i2c_com write engine between NUM_REQ camera register-configuration sequencers, one per OV5640 channel of the multi-channel splicer.
- Each sequencer requests one 32-bit write at a time, formatted {dev_addr8, reg_addr16, value8}.
- Grants are round-robin. The block owns the start/i2c_data/tr_end handshake with i2c_com and returns a per-requester done/err result.
- Runs in the I2C clock domain (the 20 kHz divided clock).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of one I2C write word.
- TIMEOUT, 4095, clock_i2c cycles to wait for tr_end before aborting.

Ports:
- clock_i2c  in  1  I2C-domain clock; the only clock.
- camera_rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-requester write request (level).
- req_data  in  NUM_REQ*DATA_W  flattened write words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- err  out  NUM_REQ  one-cycle pulse coincident with done on NACK or timeout.
- busy  out  1  high whenever state is not IDLE.
- cur_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- i2c_data  out  DATA_W  word driven to i2c_com.
- start  out  1  i2c_com start; held high until tr_end or abort.
- tr_end  in  1  i2c_com transfer-end flag.
- ack  in  1  i2c_com acknowledge status; 1 = all bytes ACKed, sampled on the cycle tr_end is seen.

Behaviour:
- All outputs are registered. Reset values: gnt=0, done=0, err=0, busy=0, cur_id=0, i2c_data=0, start=0, state=IDLE, timeout counter=0, round-robin pointer such that requester 0 has highest priority first.
- FSM states: IDLE, WAIT_END, RELEASE.
- IDLE:
  - When any req bit is 1, select the first set bit scanning upward (with wrap) from cur_id+1. After reset the scan starts at 0.
  - Next cycle: gnt is one-hot for the winner, cur_id = winner, i2c_data = winner's req_data slice (captured once, ignored thereafter), start=1, busy=1, counter cleared. Go to WAIT_END.
  - Latency from req sampled to start high: 1 cycle.
- WAIT_END:
  - Counter increments each cycle.
  - On tr_end=1: start=0, gnt=0, done[cur_id]=1 for one cycle, err[cur_id]=~ack. Go to RELEASE.
  - If the counter reaches TIMEOUT with tr_end still 0: start=0, gnt=0, done[cur_id]=1 and err[cur_id]=1. Go to RELEASE.
  - If tr_end and timeout occur on the same cycle, tr_end wins: err reflects ack only.
- RELEASE:
  - Stay until tr_end=0, so a stale tr_end cannot end the next transfer. Then go to IDLE with busy=0.
  - Earliest next start: 2 cycles after the done pulse.
- Requester rules:
  - Deasserting req during its own transaction has no effect; the transfer completes and done is still pulsed.
  - A requester that keeps req high is served again only after every other pending requester has been granted once.
  - Non-granted req bits are simply held pending; nothing is dropped.
  - req changes in RELEASE are ignored until IDLE.
- Reset asserted mid-transaction: start drops on the next edge, with no done or err pulse. The i2c_com engine is reset by the same source.
- At most one bit of gnt/done/err is ever set. done and err never pulse outside the done cycle.

Test Plan:
- Single request: req=4'b0010, req_data[63:32]=32'h78310311, tr_end pulsed after 40 cycles with ack=1 -> 1 cycle after req: gnt=4'b0010, start=1, i2c_data=32'h78310311, cur_id=1; after tr_end: done=4'b0010 for 1 cycle, err=0, start=0.
- Simultaneous requests: req=4'b1111 held, each transfer acked -> grant order 0,1,2,3,0, with every done matching the preceding gnt.
- Fairness: req[0] held permanently, req[2] asserted during requester 0's transfer -> next grant goes to 2, not 0.
- NACK: tr_end=1 with ack=0 -> done and err pulse together for the owner, and the next grant proceeds normally.
- Timeout: TIMEOUT=16, tr_end never asserted -> at cycle 16 after start: start=0, done and err pulse; with tr_end then held high, the FSM stays in RELEASE until tr_end falls.
- Reset mid-transfer: camera_rst=1 during WAIT_END -> next edge all outputs 0, no done; after release with req=4'b1000 the grant goes to 3, and with req=4'b1001 it goes to 0.
